// File: rtl/dma_pkg.sv
// Shared definitions for the dma_copier block: FSM state encoding and bus word geometry.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } dma_state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned DEF_LEN_W  = 16;

endpackage

// File: rtl/dma_copier_if.sv
// Memory bus seen by the DMA copier: the initiator drives strobes/address/write data,
// the slave side returns combinational read data and a stall request.
interface dma_copier_if
  import dma_pkg::*;
#(
  parameter int ADDR_W = 32
);

  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              bus_wait;

  modport master (
    output rd, wr, addr, wdata,
    input  rdata, bus_wait
  );

  modport slave (
    input  rd, wr, addr, wdata,
    output rdata, bus_wait
  );

endinterface

// File: rtl/dma_copier.sv
// Word-granular memory copier: READ/WRITE ping-pong on the shared bus, sticky irq on completion.
// Optional constant-fill mode (one write per cycle, no reads) is built when DMA_FILL_EN is defined.
module dma_copier
  import dma_pkg::*;
#(
  parameter int LEN_W  = DEF_LEN_W,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  input  logic              irq_clr,
`ifdef DMA_FILL_EN
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_val,
`endif
  dma_copier_if.master      bus,
  output logic              busy,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(WORD_BYTES);
  localparam logic [LEN_W-1:0]  CNT_ONE   = LEN_W'(1);
  localparam logic [LEN_W-1:0]  CNT_ZERO  = LEN_W'(0);

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              busy_q, busy_d;
  logic              irq_q, irq_d;
  logic              fill_q, fill_d;

  logic              fill_in_s;
  logic [DATA_W-1:0] fill_val_s;
  logic [ADDR_W-1:0] src_al_s;
  logic [ADDR_W-1:0] dst_al_s;
  logic [ADDR_W-1:0] dst_inc_s;
  logic [LEN_W-1:0]  cnt_dec_s;

`ifdef DMA_FILL_EN
  assign fill_in_s  = fill;
  assign fill_val_s = fill_val;
`else
  assign fill_in_s  = 1'b0;
  assign fill_val_s = {DATA_W{1'b0}};
`endif

  // Byte addresses are forced onto word boundaries when latched.
  assign src_al_s  = {src[ADDR_W-1:2], 2'b00};
  assign dst_al_s  = {dst[ADDR_W-1:2], 2'b00};
  assign dst_inc_s = dst_q + ADDR_STEP;
  assign cnt_dec_s = cnt_q - CNT_ONE;

  // Next-state and next-output logic; strobes are decoded from the state being entered.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    busy_d  = busy_q;
    fill_d  = fill_q;
    if (irq_clr) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end

    case (state_q)
      IDLE: begin
        rd_d = 1'b0;
        wr_d = 1'b0;
        if (start) begin
          src_d  = src_al_s;
          dst_d  = dst_al_s;
          cnt_d  = len;
          fill_d = fill_in_s;
          busy_d = 1'b1;
          if (len == CNT_ZERO) begin
            state_d = DONE;
          end else if (fill_in_s) begin
            state_d = WRITE;
            data_d  = fill_val_s;
            wr_d    = 1'b1;
            addr_d  = dst_al_s;
          end else begin
            state_d = READ;
            rd_d    = 1'b1;
            addr_d  = src_al_s;
          end
        end else begin
          state_d = IDLE;
        end
      end

      READ: begin
        if (!bus.bus_wait) begin
          data_d  = bus.rdata;
          src_d   = src_q + ADDR_STEP;
          state_d = WRITE;
          rd_d    = 1'b0;
          wr_d    = 1'b1;
          addr_d  = dst_q;
        end else begin
          state_d = READ;
        end
      end

      WRITE: begin
        if (!bus.bus_wait) begin
          dst_d = dst_inc_s;
          cnt_d = cnt_dec_s;
          if (cnt_dec_s == CNT_ZERO) begin
            state_d = DONE;
            wr_d    = 1'b0;
          end else if (fill_q) begin
            state_d = WRITE;
            addr_d  = dst_inc_s;
          end else begin
            state_d = READ;
            wr_d    = 1'b0;
            rd_d    = 1'b1;
            addr_d  = src_q;
          end
        end else begin
          state_d = WRITE;
        end
      end

      DONE: begin
        // Setting irq here after the clear above makes a same-cycle set win.
        state_d = IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        busy_d  = 1'b0;
        irq_d   = 1'b1;
      end

      default: begin
        state_d = IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      src_q   <= {ADDR_W{1'b0}};
      dst_q   <= {ADDR_W{1'b0}};
      addr_q  <= {ADDR_W{1'b0}};
      cnt_q   <= {LEN_W{1'b0}};
      data_q  <= {DATA_W{1'b0}};
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      irq_q   <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      irq_q   <= irq_d;
      fill_q  <= fill_d;
    end
  end

  assign bus.rd    = rd_q;
  assign bus.wr    = wr_q;
  assign bus.addr  = addr_q;
  assign bus.wdata = data_q;
  assign busy      = busy_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_dma_copier.sv
// Self-checking bench for dma_copier: a 256-word memory slave plus a queue-based copy model.
module tb_dma_copier;

  localparam int LEN_W  = 16;
  localparam int ADDR_W = 32;

  logic              clk     = 1'b0;
  logic              reset   = 1'b0;
  logic              start   = 1'b0;
  logic              irq_clr = 1'b0;
  logic [31:0]       src_i   = 32'h0;
  logic [31:0]       dst_i   = 32'h0;
  logic [LEN_W-1:0]  len_i   = 16'h0;
  logic              busy;
  logic              irq;
`ifdef DMA_FILL_EN
  logic              fill_i     = 1'b0;
  logic [31:0]       fill_val_i = 32'h0;
`endif

  dma_copier_if #(.ADDR_W(ADDR_W)) bif ();

  dma_copier #(.LEN_W(LEN_W), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .src      (src_i),
    .dst      (dst_i),
    .len      (len_i),
    .irq_clr  (irq_clr),
`ifdef DMA_FILL_EN
    .fill     (fill_i),
    .fill_val (fill_val_i),
`endif
    .bus      (bif.master),
    .busy     (busy),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  always_comb bif.rdata = bif.rd ? mem[bif.addr[9:2]] : 32'h0;

  int          n_vec = 0;
  int          n_err = 0;
  int          busy_cnt;
  int          n_waits;
  int unsigned wait_pct = 0;
  int          stall_budget = 0;
  logic        prev_stall = 1'b0;
  logic        prev_rd = 1'b0;
  logic        prev_wr = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] obs_rd [$];
  logic [63:0] obs_wr [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe outputs mid-cycle, play the slave (stall choice, read log, memory write).
  task automatic step();
    logic w;
    @(posedge clk);
    @(negedge clk);
    if (busy) busy_cnt++;
    chk("strobe_excl", 64'(bif.rd & bif.wr), 64'd0);
    if (prev_stall) begin
      chk("stall_addr_hold", 64'(bif.addr), 64'(prev_addr));
      chk("stall_strobe_hold", 64'({bif.rd, bif.wr}), 64'({prev_rd, prev_wr}));
    end
    w = 1'b0;
    if (bif.rd || bif.wr) begin
      if (bif.rd && obs_rd.size() == 1 && stall_budget > 0) begin
        w = 1'b1;
        stall_budget--;
      end else if ($urandom_range(99) < wait_pct) begin
        w = 1'b1;
      end else begin
        w = 1'b0;
      end
    end
    bif.bus_wait = w;
    if (w) n_waits++;
    #1;
    if (!w && bif.rd) obs_rd.push_back(bif.addr);
    if (!w && bif.wr) begin
      obs_wr.push_back({bif.addr, bif.wdata});
      mem[bif.addr[9:2]] = bif.wdata;
    end
    prev_stall = w;
    prev_addr  = bif.addr;
    prev_rd    = bif.rd;
    prev_wr    = bif.wr;
  endtask

  // Run one transfer and compare the bus traffic, timing and memory image with the model.
  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                          input bit f, input logic [31:0] fv, input int unsigned wp,
                          input int stall, input bit mid_start);
    logic [31:0] ref_mem [256];
    logic [31:0] exp_rd [$];
    logic [63:0] exp_wr [$];
    logic [31:0] a, b, v;
    int          guard, exp_busy, mism;
    ref_mem = mem;
    a = s & 32'hFFFF_FFFC;
    b = d & 32'hFFFF_FFFC;
    for (int i = 0; i < int'(n); i++) begin
      if (f) begin
        v = fv;
      end else begin
        v = ref_mem[a[9:2]];
        exp_rd.push_back(a);
      end
      ref_mem[b[9:2]] = v;
      exp_wr.push_back({b, v});
      a = a + 32'd4;
      b = b + 32'd4;
    end
    obs_rd.delete();
    obs_wr.delete();
    busy_cnt     = 0;
    n_waits      = 0;
    wait_pct     = wp;
    stall_budget = stall;
    src_i = s;
    dst_i = d;
    len_i = n;
`ifdef DMA_FILL_EN
    fill_i     = f;
    fill_val_i = fv;
`endif
    start = 1'b1;
    step();
    start = 1'b0;
    guard = 0;
    while (busy && guard < 5000) begin
      if (mid_start && guard == 2) begin
        start = 1'b1;
        src_i = 32'h200;
        dst_i = 32'h300;
        len_i = 16'd7;
      end else begin
        start = 1'b0;
      end
      step();
      guard++;
    end
    start = 1'b0;
    chk("xfer_done_in_budget", 64'(guard < 5000), 64'd1);
    exp_busy = (f ? int'(n) : 2 * int'(n)) + 1 + n_waits;
    chk("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
    chk("read_count", 64'(obs_rd.size()), 64'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++)
      chk("read_addr", 64'(obs_rd[i]), 64'(exp_rd[i]));
    chk("write_count", 64'(obs_wr.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
      chk("write_addr_data", obs_wr[i], exp_wr[i]);
    mism = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i]) mism++;
    chk("mem_image", 64'(mism), 64'd0);
    chk("irq_after_done", 64'(irq), 64'd1);
  endtask

  initial begin
    logic [31:0] rs, rd_a;
    logic [31:0] keep2, keep3;
    int          guard;
    bif.bus_wait = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;

    // Reset state
    reset = 1'b0;
    repeat (3) step();
    chk("reset_addr", 64'(bif.addr), 64'd0);
    chk("reset_wdata", 64'(bif.wdata), 64'd0);
    chk("reset_rd_wr_busy_irq", 64'({bif.rd, bif.wr, busy, irq}), 64'd0);
    reset = 1'b1;
    step();

    // Basic 4-word copy
    mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3; mem[3] = 32'd4;
    run_xfer(32'h0, 32'h40, 16'd4, 1'b0, 32'h0, 0, 0, 1'b0);
    chk("copy4_busy9", 64'(busy_cnt), 64'd9);
    for (int i = 0; i < 4; i++) chk("copy4_dst_word", 64'(mem[16 + i]), 64'(i + 1));

    // Clear irq, then zero length
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    chk("irq_cleared", 64'(irq), 64'd0);
    run_xfer(32'h10, 32'h90, 16'd0, 1'b0, 32'h0, 0, 0, 1'b0);
    chk("zero_len_busy1", 64'(busy_cnt), 64'd1);

    // 3-cycle stall on the second read of a 2-word copy
    run_xfer(32'h20, 32'hA0, 16'd2, 1'b0, 32'h0, 0, 3, 1'b0);
    chk("stall_waits", 64'(n_waits), 64'd3);
    chk("stall_busy8", 64'(busy_cnt), 64'd8);

    // Unaligned source with address wrap
    run_xfer(32'hFFFF_FFFE, 32'hC0, 16'd2, 1'b0, 32'h0, 0, 0, 1'b0);
    if (obs_rd.size() == 2) begin
      chk("wrap_rd0", 64'(obs_rd[0]), 64'hFFFF_FFFC);
      chk("wrap_rd1", 64'(obs_rd[1]), 64'h0);
    end else begin
      chk("wrap_rd_count", 64'(obs_rd.size()), 64'd2);
    end

    // irq set and clear in the same cycle: set wins, then clear takes effect
    irq_clr = 1'b1;
    run_xfer(32'h0, 32'h0, 16'd0, 1'b0, 32'h0, 0, 0, 1'b0);
    step();
    chk("irq_clear_after_collision", 64'(irq), 64'd0);
    irq_clr = 1'b0;

    // start while busy is ignored
    run_xfer(32'h100, 32'h140, 16'd5, 1'b0, 32'h0, 20, 0, 1'b1);

    // Random copies with random stalls, overlap allowed
    for (int k = 0; k < 8; k++) begin
      rs   = $urandom & 32'h3FF;
      rd_a = $urandom & 32'h3FF;
      run_xfer(rs, rd_a, 16'($urandom_range(12)), 1'b0, 32'h0, 25, 0, 1'b0);
    end

`ifdef DMA_FILL_EN
    run_xfer(32'h0, 32'h180, 16'd3, 1'b1, 32'hDEAD_BEEF, 0, 0, 1'b0);
    chk("fill_busy4", 64'(busy_cnt), 64'd4);
    chk("fill_no_reads", 64'(obs_rd.size()), 64'd0);
    for (int k = 0; k < 3; k++)
      run_xfer($urandom & 32'h3FF, $urandom & 32'h3FF, 16'($urandom_range(9)), 1'b1,
               $urandom, 25, 0, 1'b0);
    fill_i = 1'b0;
`endif

    // Reset during the write of word 2 of 4
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    keep2 = mem[114];
    keep3 = mem[115];
    obs_rd.delete();
    obs_wr.delete();
    wait_pct     = 0;
    stall_budget = 0;
    src_i = 32'h0;
    dst_i = 32'h1C0;
    len_i = 16'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    guard = 0;
    while (obs_wr.size() < 2 && guard < 100) begin
      step();
      guard++;
    end
    chk("reach_write2", 64'(obs_wr.size()), 64'd2);
    reset = 1'b0;
    step();
    chk("midreset_rd_wr_busy_irq", 64'({bif.rd, bif.wr, busy, irq}), 64'd0);
    reset = 1'b1;
    repeat (10) step();
    chk("midreset_no_more_writes", 64'(obs_wr.size()), 64'd2);
    chk("midreset_word1", 64'(mem[112]), 64'h11);
    chk("midreset_word2", 64'(mem[113]), 64'h22);
    chk("midreset_word3_untouched", 64'(mem[114]), 64'(keep2));
    chk("midreset_word4_untouched", 64'(mem[115]), 64'(keep3));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dma_copier.md
Name: dma_copier

Overview:
- Memory-bus initiator: copies a block of 32-bit words from a source region to a destination region of data memory.
- Drives the same rd/wr/addr/wdata/rdata bus the data memory and peripheral slaves respond to; sits beside the CPU data port behind a bus mux, with the CPU given priority outside busy.
- Raises a sticky interrupt on completion, same style as the peripheral irq.

Parameters:
- LEN_W, 16, width of the word-count register (max transfer 2^LEN_W-1 words).
- ADDR_W, 32, bus address width.

Ports:
- clk  input  1  system clock (CPU clock domain).
- reset  input  1  synchronous reset, active-low (reset==0 resets on posedge clk).
- start  input  1  one-cycle pulse; latches src/dst/len and begins the transfer if idle.
- src  input  ADDR_W  source byte address; bits [1:0] ignored (forced 0).
- dst  input  ADDR_W  destination byte address; bits [1:0] ignored.
- len  input  LEN_W  transfer length in words.
- irq_clr  input  1  clears irq.
- bus_wait  input  1  slave stall; the current bus cycle repeats while high.
- rd  output  1  bus read strobe.
- wr  output  1  bus write strobe.
- addr  output  ADDR_W  bus address.
- wdata  output  32  bus write data.
- rdata  input  32  bus read data, combinational, valid in the same cycle as rd.
- busy  output  1  high from the cycle after an accepted start until DONE exits.
- irq  output  1  sticky completion flag.

Behaviour:
- Reset values: rd=0, wr=0, addr=0, wdata=0, busy=0, irq=0, state=IDLE, all internal counters 0.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - start=1 latches src_q={src[ADDR_W-1:2],2'b00}, dst_q likewise, and cnt=len.
  - If len==0, go to DONE; otherwise go to READ.
  - start is ignored outside IDLE.
- READ:
  - rd=1, addr=src_q.
  - If bus_wait=0: latch data_q=rdata at the clock edge, src_q+=4, go to WRITE.
  - If bus_wait=1: stay in READ with outputs unchanged.
- WRITE:
  - wr=1, addr=dst_q, wdata=data_q.
  - If bus_wait=0: dst_q+=4, cnt-=1; go to DONE if the new cnt==0, else go to READ.
  - If bus_wait=1: hold.
- DONE: one cycle; irq<=1, then go to IDLE.
- Strobe rules:
  - rd and wr are never high together.
  - Both are 0 in IDLE and DONE.
  - addr and wdata hold their last values when idle.
- Throughput: 2 cycles per word with no waits. An N-word copy ends busy after 2N+1 cycles from the start edge (includes DONE).
- Address arithmetic is modulo 2^ADDR_W; wrap from 0xFFFFFFFC to 0x00000000 is legal and not flagged.
- Overlapping regions: copies in ascending order, no overlap protection (dst>src with overlap replicates data; this is documented, not an error).
- irq:
  - Set in DONE; cleared by irq_clr.
  - If set and clear happen in the same cycle, set wins.
- Reset mid-transfer: abort immediately, strobes drop in the same edge, no partial write completes after reset deasserts.

Optional Feature:
- Macro DMA_FILL_EN.
- With it defined:
  - Adds input fill (1 bit) and fill_val (32 bits), sampled at start.
  - When fill=1, the READ state is skipped: data_q=fill_val, transfer goes IDLE->WRITE, 1 cycle per word.
  - An N-word fill ends busy after N+1 cycles from the start edge.
- Without it: ports absent, copy only.

Decomposition:
- Shared package dma_pkg:
  - State encoding enum (IDLE=2'd0, READ=2'd1, WRITE=2'd2, DONE=2'd3).
  - WORD_BYTES=4.
  - Default LEN_W.
- No sub-module needed: single FSM plus three registers. Bus mux arbitration between CPU and DMA lives outside this block.

Test Plan:
- Copy: mem[0x00..0x0C]={1,2,3,4}, start src=0x00 dst=0x40 len=4, bus_wait=0 -> mem[0x40..0x4C]={1,2,3,4}; busy high 9 cycles; irq=1 afterward; rd/wr alternate, never both high.
- Zero length: start len=0 -> no rd/wr ever; busy 1 cycle (DONE); irq=1.
- Stall: bus_wait=1 for 3 cycles during the second READ of a 2-word copy -> addr/rd held those 3 cycles; data correct; busy lasts 5+3=8 cycles.
- Unaligned + wrap: src=0xFFFFFFFE, len=2 -> reads at 0xFFFFFFFC then 0x00000000.
- Reset mid-transfer: reset=0 during WRITE of word 2 of 4 -> next cycle rd=wr=0, busy=0, irq=0; words 3 and 4 untouched.
- irq set/clear collision, and start while busy ignored (src unchanged). With DMA_FILL_EN: fill=1, fill_val=0xDEADBEEF, len=3 -> three writes of 0xDEADBEEF, zero reads, busy 4 cycles.
